reservation_station: RTL and testbench

Out-of-order instruction buffer between dispatch and one functional unit. It accepts renamed instructions from dispatch and holds each one until both source operands are ready. Waiting operands are captured from the common data bus (CDB). Each cycle it issues the oldest fully-ready entry to the functional unit through a registered output stage.

---
 rtl/reservation_station.sv | 224 ++++++++++++++++++++++
 tb/tb_reservation_station.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// reservation_station: buffers renamed instructions until both operands are ready and issues the
// oldest ready one through a registered stage. Optional macro RS_ISSUE_BYPASS_EN: a ready dispatch skips the buffer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package reservation_station_pkg;
    localparam int unsigned TAG_WIDTH    = 6;
    localparam int unsigned OPCODE_WIDTH = 4;

    typedef logic [TAG_WIDTH-1:0]    procyon_tag_t;
    typedef logic [OPCODE_WIDTH-1:0] procyon_opcode_t;

    typedef struct packed {
        procyon_opcode_t              opcode;
        logic [`ADDR_WIDTH-1:0]       iaddr;
        logic [`DATA_WIDTH-1:0]       insn;
        procyon_tag_t [1:0]           src_tag;
        logic [1:0][`DATA_WIDTH-1:0]  src_data;
        logic [1:0]                   src_rdy;
        procyon_tag_t                 dst_tag;
    } rs_entry_t;

    typedef struct packed {
        procyon_opcode_t        opcode;
        logic [`ADDR_WIDTH-1:0] iaddr;
        logic [`DATA_WIDTH-1:0] insn;
        logic [`DATA_WIDTH-1:0] src_a;
        logic [`DATA_WIDTH-1:0] src_b;
        procyon_tag_t           dst_tag;
    } rs_issue_t;
endpackage

module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int unsigned RS_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   i_flush,
    input  logic                   i_rs_en,
    input  procyon_opcode_t        i_rs_opcode,
    input  logic [`ADDR_WIDTH-1:0] i_rs_iaddr,
    input  logic [`DATA_WIDTH-1:0] i_rs_insn,
    input  procyon_tag_t           i_rs_src_tag  [0:1],
    input  logic [`DATA_WIDTH-1:0] i_rs_src_data [0:1],
    input  logic                   i_rs_src_rdy  [0:1],
    input  procyon_tag_t           i_rs_dst_tag,
    output logic                   o_rs_stall,
    input  logic                   i_cdb_en,
    input  procyon_tag_t           i_cdb_tag,
    input  logic [`DATA_WIDTH-1:0] i_cdb_data,
    input  logic                   i_fu_stall,
    output logic                   o_fu_valid,
    output procyon_opcode_t        o_fu_opcode,
    output logic [`ADDR_WIDTH-1:0] o_fu_iaddr,
    output logic [`DATA_WIDTH-1:0] o_fu_insn,
    output logic [`DATA_WIDTH-1:0] o_fu_src_a,
    output logic [`DATA_WIDTH-1:0] o_fu_src_b,
    output procyon_tag_t           o_fu_dst_tag
);
    localparam int unsigned IDX_WIDTH = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] valid_q, valid_d;
    rs_entry_t           entry_q [RS_DEPTH];
    rs_entry_t           entry_d [RS_DEPTH];
    logic [RS_DEPTH-1:0] age_q   [RS_DEPTH];
    logic [RS_DEPTH-1:0] age_d   [RS_DEPTH];
    rs_issue_t           fu_q, fu_d;
    logic                fu_valid_q, fu_valid_d;

    rs_entry_t           disp;
    logic [RS_DEPTH-1:0] ready_vec, blocked, sel_vec;
    logic                sel_any, free_any, alloc_en, bypass;
    logic [IDX_WIDTH-1:0] sel_idx, free_idx;

    function automatic rs_issue_t to_issue(input rs_entry_t e);
        rs_issue_t r;
        r.opcode  = e.opcode;
        r.iaddr   = e.iaddr;
        r.insn    = e.insn;
        r.src_a   = e.src_data[0];
        r.src_b   = e.src_data[1];
        r.dst_tag = e.dst_tag;
        return r;
    endfunction

    assign o_rs_stall = &valid_q;
    assign alloc_en   = i_rs_en && !o_rs_stall && !i_flush;

    // Dispatched entry, including a source produced on the CDB in the same cycle
    always_comb begin
        disp.opcode  = i_rs_opcode;
        disp.iaddr   = i_rs_iaddr;
        disp.insn    = i_rs_insn;
        disp.dst_tag = i_rs_dst_tag;
        for (int s = 0; s < 2; s++) begin
            disp.src_tag[s]  = i_rs_src_tag[s];
            disp.src_data[s] = i_rs_src_data[s];
            disp.src_rdy[s]  = i_rs_src_rdy[s];
            if (!i_rs_src_rdy[s] && i_cdb_en && (i_rs_src_tag[s] == i_cdb_tag)) begin
                disp.src_data[s] = i_cdb_data;
                disp.src_rdy[s]  = 1'b1;
            end
        end
    end

    // Oldest ready entry: ready and no other ready entry is older than it
    always_comb begin
        ready_vec = '0;
        blocked   = '0;
        sel_vec   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready_vec[i] = valid_q[i] && (&entry_q[i].src_rdy);
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && ready_vec[j] && age_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
            sel_vec[i] = ready_vec[i] && !blocked[i];
        end
    end

    always_comb begin
        sel_any  = 1'b0;
        sel_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                sel_any = 1'b1;
                sel_idx = IDX_WIDTH'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_WIDTH'(i);
            end
        end
    end

`ifdef RS_ISSUE_BYPASS_EN
    assign bypass = alloc_en && (&disp.src_rdy) && !(|ready_vec) && !i_fu_stall;
`else
    assign bypass = 1'b0;
`endif

    // Wakeup, select, allocate, flush; flush has the last word
    always_comb begin
        valid_d    = valid_q;
        entry_d    = entry_q;
        age_d      = age_q;
        fu_valid_d = fu_valid_q;
        fu_d       = fu_q;

        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (valid_q[i] && !entry_q[i].src_rdy[s] && i_cdb_en &&
                    (entry_q[i].src_tag[s] == i_cdb_tag)) begin
                    entry_d[i].src_data[s] = i_cdb_data;
                    entry_d[i].src_rdy[s]  = 1'b1;
                end
            end
        end

        if (!i_fu_stall) begin
            fu_valid_d = sel_any;
            if (sel_any) begin
                fu_d             = to_issue(entry_q[sel_idx]);
                valid_d[sel_idx] = 1'b0;
            end
        end

        if (bypass) begin
            fu_valid_d = 1'b1;
            fu_d       = to_issue(disp);
        end else if (alloc_en && free_any) begin
            valid_d[free_idx] = 1'b1;
            entry_d[free_idx] = disp;
            for (int j = 0; j < RS_DEPTH; j++) begin
                age_d[j][free_idx] = valid_q[j];
            end
            age_d[free_idx] = '0;
        end

        if (i_flush) begin
            valid_d    = '0;
            fu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q    <= '0;
            fu_valid_q <= 1'b0;
            fu_q       <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            fu_valid_q <= fu_valid_d;
            fu_q       <= fu_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
                age_q[i]   <= age_d[i];
            end
        end
    end

    assign o_fu_valid   = fu_valid_q;
    assign o_fu_opcode  = fu_q.opcode;
    assign o_fu_iaddr   = fu_q.iaddr;
    assign o_fu_insn    = fu_q.insn;
    assign o_fu_src_a   = fu_q.src_a;
    assign o_fu_src_b   = fu_q.src_b;
    assign o_fu_dst_tag = fu_q.dst_tag;
endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station in its default (no bypass) build.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            i_flush, i_rs_en, i_cdb_en, i_fu_stall;
    procyon_opcode_t i_rs_opcode;
    logic [31:0]     i_rs_iaddr, i_rs_insn, i_cdb_data;
    procyon_tag_t    i_rs_src_tag  [0:1];
    logic [31:0]     i_rs_src_data [0:1];
    logic            i_rs_src_rdy  [0:1];
    procyon_tag_t    i_rs_dst_tag, i_cdb_tag;
    logic            o_rs_stall, o_fu_valid;
    procyon_opcode_t o_fu_opcode;
    logic [31:0]     o_fu_iaddr, o_fu_insn, o_fu_src_a, o_fu_src_b;
    procyon_tag_t    o_fu_dst_tag;

    int total = 0;
    int bad   = 0;

    reservation_station #(.RS_DEPTH(4)) dut (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .i_rs_en(i_rs_en),
        .i_rs_opcode(i_rs_opcode), .i_rs_iaddr(i_rs_iaddr), .i_rs_insn(i_rs_insn),
        .i_rs_src_tag(i_rs_src_tag), .i_rs_src_data(i_rs_src_data), .i_rs_src_rdy(i_rs_src_rdy),
        .i_rs_dst_tag(i_rs_dst_tag), .o_rs_stall(o_rs_stall),
        .i_cdb_en(i_cdb_en), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
        .i_fu_stall(i_fu_stall), .o_fu_valid(o_fu_valid), .o_fu_opcode(o_fu_opcode),
        .o_fu_iaddr(o_fu_iaddr), .o_fu_insn(o_fu_insn), .o_fu_src_a(o_fu_src_a),
        .o_fu_src_b(o_fu_src_b), .o_fu_dst_tag(o_fu_dst_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [5:0] t0, input logic [31:0] d0,
                            input logic r0, input logic [5:0] t1, input logic [31:0] d1,
                            input logic r1, input logic [5:0] dst);
        i_rs_en          = 1'b1;
        i_rs_opcode      = op;
        i_rs_iaddr       = 32'h1000 + 32'(dst);
        i_rs_insn        = 32'hA000 + 32'(dst);
        i_rs_src_tag[0]  = t0;
        i_rs_src_data[0] = d0;
        i_rs_src_rdy[0]  = r0;
        i_rs_src_tag[1]  = t1;
        i_rs_src_data[1] = d1;
        i_rs_src_rdy[1]  = r1;
        i_rs_dst_tag     = dst;
    endtask

    task automatic cdb(input logic en, input logic [5:0] tag, input logic [31:0] data);
        i_cdb_en   = en;
        i_cdb_tag  = tag;
        i_cdb_data = data;
    endtask

    initial begin
        n_rst = 1'b0;
        i_flush = 1'b0; i_rs_en = 1'b0; i_fu_stall = 1'b0;
        dispatch(4'h0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
        i_rs_en = 1'b0;
        cdb(1'b0, 6'd0, 32'd0);
        tick();
        check("rst_stall", 32'(o_rs_stall), 32'd0);
        check("rst_fu_valid", 32'(o_fu_valid), 32'd0);
        check("rst_src_a", o_fu_src_a, 32'd0);
        check("rst_dst", 32'(o_fu_dst_tag), 32'd0);
        n_rst = 1'b1;
        tick();

        // ADDI with ready operands: two edges to issue
        dispatch(4'h1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd0, 1'b1, 6'd3);
        tick();
        i_rs_en = 1'b0;
        check("addi_e0_valid", 32'(o_fu_valid), 32'd0);
        tick();
        check("addi_e1_valid", 32'(o_fu_valid), 32'd1);
        check("addi_src_a", o_fu_src_a, 32'd5);
        check("addi_dst", 32'(o_fu_dst_tag), 32'd3);
        check("addi_op", 32'(o_fu_opcode), 32'd1);
        check("addi_iaddr", o_fu_iaddr, 32'h1003);
        tick();
        check("addi_drain", 32'(o_fu_valid), 32'd0);

        // OP waiting on tag 7, woken by the CDB
        dispatch(4'h2, 6'd0, 32'd2, 1'b1, 6'd7, 32'd0, 1'b0, 6'd5);
        tick();
        i_rs_en = 1'b0;
        tick();
        check("op_wait", 32'(o_fu_valid), 32'd0);
        cdb(1'b1, 6'd7, 32'hABCD);
        tick();
        cdb(1'b0, 6'd0, 32'd0);
        check("op_wake_e0", 32'(o_fu_valid), 32'd0);
        tick();
        check("op_issue_valid", 32'(o_fu_valid), 32'd1);
        check("op_src_b", o_fu_src_b, 32'hABCD);
        check("op_src_a", o_fu_src_a, 32'd2);
        check("op_dst", 32'(o_fu_dst_tag), 32'd5);
        tick();

        // Fill all entries waiting on tag 9
        for (int k = 0; k < 4; k++) begin
            dispatch(4'h3, 6'd9, 32'd0, 1'b0, 6'd0, 32'(k), 1'b1, 6'(10 + k));
            tick();
        end
        check("full_stall", 32'(o_rs_stall), 32'd1);
        dispatch(4'h3, 6'd9, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd20);
        tick();
        i_rs_en = 1'b0;
        check("full_ignored_stall", 32'(o_rs_stall), 32'd1);
        cdb(1'b1, 6'd9, 32'h99);
        tick();
        cdb(1'b0, 6'd0, 32'd0);
        check("full_wake_valid", 32'(o_fu_valid), 32'd0);
        tick();
        check("full_issue0_dst", 32'(o_fu_dst_tag), 32'd10);
        check("full_issue0_src_a", o_fu_src_a, 32'h99);
        check("full_stall_drop", 32'(o_rs_stall), 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("full_issue_valid", 32'(o_fu_valid), 32'd1);
            check("full_issue_dst", 32'(o_fu_dst_tag), 32'(10 + k));
            check("full_issue_src_b", o_fu_src_b, 32'(k));
        end
        tick();
        check("full_no_extra", 32'(o_fu_valid), 32'd0);

        // Capture from the CDB in the dispatch cycle
        dispatch(4'h4, 6'd4, 32'd0, 1'b0, 6'd0, 32'd8, 1'b1, 6'd6);
        cdb(1'b1, 6'd4, 32'h11);
        tick();
        i_rs_en = 1'b0;
        cdb(1'b0, 6'd0, 32'd0);
        tick();
        check("capture_valid", 32'(o_fu_valid), 32'd1);
        check("capture_src_a", o_fu_src_a, 32'h11);
        check("capture_dst", 32'(o_fu_dst_tag), 32'd6);
        tick();

        // FU stall holds the issue register
        dispatch(4'h5, 6'd0, 32'd21, 1'b1, 6'd0, 32'd1, 1'b1, 6'd21);
        tick();
        dispatch(4'h6, 6'd0, 32'd22, 1'b1, 6'd0, 32'd2, 1'b1, 6'd22);
        tick();
        i_rs_en = 1'b0;
        i_fu_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", 32'(o_fu_valid), 32'd1);
            check("stall_dst", 32'(o_fu_dst_tag), 32'd21);
            check("stall_src_a", o_fu_src_a, 32'd21);
        end
        i_fu_stall = 1'b0;
        tick();
        check("unstall_dst", 32'(o_fu_dst_tag), 32'd22);
        check("unstall_op", 32'(o_fu_opcode), 32'd6);
        tick();
        check("unstall_drain", 32'(o_fu_valid), 32'd0);

        // Flush with a simultaneous dispatch
        dispatch(4'h7, 6'd0, 32'd40, 1'b1, 6'd0, 32'd0, 1'b1, 6'd40);
        tick();
        dispatch(4'h7, 6'd30, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd41);
        tick();
        i_fu_stall = 1'b1;
        dispatch(4'h7, 6'd30, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd42);
        tick();
        dispatch(4'h7, 6'd30, 32'd0, 1'b0, 6'd0, 32'd0, 1'b1, 6'd43);
        tick();
        check("pre_flush_valid", 32'(o_fu_valid), 32'd1);
        check("pre_flush_dst", 32'(o_fu_dst_tag), 32'd40);
        dispatch(4'h7, 6'd0, 32'd50, 1'b1, 6'd0, 32'd0, 1'b1, 6'd50);
        i_flush = 1'b1;
        i_fu_stall = 1'b0;
        tick();
        i_flush = 1'b0;
        i_rs_en = 1'b0;
        check("flush_fu_valid", 32'(o_fu_valid), 32'd0);
        check("flush_stall", 32'(o_rs_stall), 32'd0);
        cdb(1'b1, 6'd30, 32'h30);
        tick();
        cdb(1'b0, 6'd0, 32'd0);
        check("flush_no_alloc0", 32'(o_fu_valid), 32'd0);
        tick();
        check("flush_no_alloc1", 32'(o_fu_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
